rs232in_framed: RTL and testbench

- Parametrised next-generation UART receiver for the serial debug/host link, successor to the fixed 8N1 receiver.
- Adds configurable data width, parity, stop-bit count and false-start rejection.
- Adds framing-error, parity-error and break detection, plus an asynchronous reset.
- Sits between the board serial pin and the host-command logic; delivers one right-aligned word per frame with a single-cycle strobe.

---
 rtl/rs232in_framed.sv | 215 +++++++++++++++++++++
 tb/tb_rs232in_framed.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs232in_framed.sv
// Parametrised asynchronous serial receiver: configurable width, parity and stop bits,
// with false-start rejection, framing/parity error flags and break detection.
module rs232in_framed #(
    parameter int bps       = 57_600,
    parameter int frequency = 25_000_000,
    parameter int period    = (frequency + bps / 2) / bps,
    parameter int data_bits = 8,
    parameter int parity    = 0,
    parameter int stop_bits = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic                 attention,
    output logic [data_bits-1:0] received_data,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 break_detect
);

    localparam int TIMER_W = $clog2(3 * period / 2 + 1);
    localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(period / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(period - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    if (data_bits < 5 || data_bits > 9) begin : g_bad_data_bits
        $error("rs232in_framed: data_bits must be 5..9");
    end
    if (parity < 0 || parity > 2) begin : g_bad_parity
        $error("rs232in_framed: parity must be 0, 1 or 2");
    end
    if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop_bits
        $error("rs232in_framed: stop_bits must be 1 or 2");
    end

    logic                 sync1_q, rxs_q;
    logic [2:0]           state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [1:0]           stop_cnt_q, stop_cnt_d;
    logic [data_bits-1:0] shift_q, shift_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 zero_q, zero_d;
    logic                 att_q, att_d;
    logic                 brk_q, brk_d;
    logic [data_bits-1:0] data_q, data_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 tick_s, par_exp_s, fe_now_s, brk_now_s;

    // Next-state logic for the frame FSM, bit timer and result registers.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        ferr_acc_d = ferr_acc_q;
        perr_acc_d = perr_acc_q;
        zero_d     = zero_q;
        att_d      = 1'b0;
        brk_d      = 1'b0;
        data_d     = data_q;
        fe_d       = fe_q;
        pe_d       = pe_q;
        tick_s     = (timer_q == {TIMER_W{1'b0}});
        par_exp_s  = (parity == 1) ? ~^shift_q : ^shift_q;
        fe_now_s   = ferr_acc_q | ~rxs_q;
        brk_now_s  = zero_q & ~rxs_q;

        if (!tick_s) begin
            timer_d = timer_q - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            timer_d = timer_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    timer_d = HALF_LOAD;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s && rxs_q) begin
                    state_d = S_IDLE;
                end else if (tick_s) begin
                    timer_d    = FULL_LOAD;
                    bit_cnt_d  = 4'(data_bits);
                    ferr_acc_d = 1'b0;
                    perr_acc_d = 1'b0;
                    zero_d     = 1'b1;
                    state_d    = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    shift_d   = {rxs_q, shift_q[data_bits-1:1]};
                    zero_d    = zero_q & ~rxs_q;
                    timer_d   = FULL_LOAD;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    if (bit_cnt_q == 4'd1) begin
                        stop_cnt_d = 2'(stop_bits);
                        state_d    = (parity != 0) ? S_PARITY : S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (tick_s) begin
                    perr_acc_d = (rxs_q != par_exp_s);
                    zero_d     = zero_q & ~rxs_q;
                    timer_d    = FULL_LOAD;
                    state_d    = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                // The final stop sample publishes the whole frame in one cycle.
                if (tick_s && stop_cnt_q == 2'd1) begin
                    att_d   = 1'b1;
                    brk_d   = brk_now_s;
                    data_d  = brk_now_s ? {data_bits{1'b0}} : shift_q;
                    fe_d    = fe_now_s;
                    pe_d    = perr_acc_q;
                    state_d = fe_now_s ? S_WAIT : S_IDLE;
                end else if (tick_s) begin
                    ferr_acc_d = fe_now_s;
                    zero_d     = zero_q & ~rxs_q;
                    stop_cnt_d = stop_cnt_q - 2'd1;
                    timer_d    = FULL_LOAD;
                    state_d    = S_STOP;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Two-flop synchroniser on the raw line, reset to the idle level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            rxs_q   <= sync1_q;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= {TIMER_W{1'b0}};
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 2'd0;
            shift_q    <= {data_bits{1'b0}};
            ferr_acc_q <= 1'b0;
            perr_acc_q <= 1'b0;
            zero_q     <= 1'b0;
            att_q      <= 1'b0;
            brk_q      <= 1'b0;
            data_q     <= {data_bits{1'b0}};
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            ferr_acc_q <= ferr_acc_d;
            perr_acc_q <= perr_acc_d;
            zero_q     <= zero_d;
            att_q      <= att_d;
            brk_q      <= brk_d;
            data_q     <= data_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
        end
    end

    assign attention     = att_q;
    assign break_detect  = brk_q;
    assign received_data = data_q;
    assign framing_error = fe_q;
    assign parity_error  = pe_q;

endmodule

// File: tb/tb_rs232in_framed.sv
// Directed plus randomized frames against three receiver configurations, checked
// against a frame-level reference model of the serial protocol.
module tb_rs232in_framed;

    localparam int P0 = 434;
    localparam int P1 = 50;
    localparam int P2 = 50;

    logic clock = 1'b0;
    logic reset;
    logic ser0, ser1, ser2;
    logic att0, fe0, pe0, bd0;
    logic att1, fe1, pe1, bd1;
    logic att2, fe2, pe2, bd2;
    logic [7:0] data0;
    logic [6:0] data1;
    logic [8:0] data2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int att_cnt [3] = '{0, 0, 0};
    int bd_cnt [3] = '{0, 0, 0};
    int att_cyc [3] = '{0, 0, 0};
    logic [8:0] cap_data [3] = '{9'd0, 9'd0, 9'd0};
    logic cap_fe [3] = '{1'b0, 1'b0, 1'b0};
    logic cap_pe [3] = '{1'b0, 1'b0, 1'b0};
    logic cap_bd [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clock = ~clock;

    rs232in_framed u_dut0 (
        .clock(clock), .reset(reset), .serial_in(ser0), .attention(att0),
        .received_data(data0), .framing_error(fe0), .parity_error(pe0), .break_detect(bd0)
    );

    rs232in_framed #(.bps(500_000), .data_bits(7), .parity(2), .stop_bits(1)) u_dut1 (
        .clock(clock), .reset(reset), .serial_in(ser1), .attention(att1),
        .received_data(data1), .framing_error(fe1), .parity_error(pe1), .break_detect(bd1)
    );

    rs232in_framed #(.bps(500_000), .data_bits(9), .parity(0), .stop_bits(2)) u_dut2 (
        .clock(clock), .reset(reset), .serial_in(ser2), .attention(att2),
        .received_data(data2), .framing_error(fe2), .parity_error(pe2), .break_detect(bd2)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // Capture every strobe cycle away from the active edge.
    always @(negedge clock) begin
        if (att0) begin
            att_cnt[0] <= att_cnt[0] + 1; cap_data[0] <= {1'b0, data0};
            cap_fe[0] <= fe0; cap_pe[0] <= pe0; cap_bd[0] <= bd0; att_cyc[0] <= cyc;
        end
        if (att1) begin
            att_cnt[1] <= att_cnt[1] + 1; cap_data[1] <= {2'b00, data1};
            cap_fe[1] <= fe1; cap_pe[1] <= pe1; cap_bd[1] <= bd1; att_cyc[1] <= cyc;
        end
        if (att2) begin
            att_cnt[2] <= att_cnt[2] + 1; cap_data[2] <= data2;
            cap_fe[2] <= fe2; cap_pe[2] <= pe2; cap_bd[2] <= bd2; att_cyc[2] <= cyc;
        end
        if (bd0) bd_cnt[0] <= bd_cnt[0] + 1;
        if (bd1) bd_cnt[1] <= bd_cnt[1] + 1;
        if (bd2) bd_cnt[2] <= bd_cnt[2] + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0: ser0 = v;
            1: ser1 = v;
            default: ser2 = v;
        endcase
    endtask

    function automatic int cfg_bits(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 7 : 9;
    endfunction

    function automatic int cfg_per(input int sel);
        return (sel == 0) ? P0 : (sel == 1) ? P1 : P2;
    endfunction

    // Parity bit that makes the total count of ones odd (mode 1) or even (mode 2).
    function automatic bit model_pbit(input logic [8:0] d, input int nb, input int pmode);
        int ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        return (pmode == 2) ? bit'(ones % 2) : bit'(1 - ones % 2);
    endfunction

    task automatic send(input int sel, input logic [8:0] d, input bit pflip,
                        input logic [1:0] stopv, input int gap_bits);
        bit q[$];
        int nb = cfg_bits(sel);
        int per = cfg_per(sel);
        int pm = (sel == 1) ? 2 : 0;
        int ns = (sel == 2) ? 2 : 1;
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) q.push_back(d[i]);
        if (pm != 0) q.push_back(model_pbit(d, nb, pm) ^ pflip);
        for (int i = 0; i < ns; i++) q.push_back(stopv[i]);
        start_cyc = cyc;
        foreach (q[i]) begin
            set_line(sel, q[i]);
            hold(per);
        end
        set_line(sel, 1'b1);
        hold(gap_bits * per);
    endtask

    task automatic expect_frame(input string tag, input int sel, input int att_before,
                                input int bd_before, input logic [8:0] d,
                                input bit fe, input bit pe, input bit bd);
        check({tag, ".att"}, att_cnt[sel] - att_before, 1);
        check({tag, ".data"}, int'(cap_data[sel]), int'(bd ? 9'd0 : d));
        check({tag, ".fe"}, int'(cap_fe[sel]), int'(fe | bd));
        check({tag, ".pe"}, int'(cap_pe[sel]), int'(pe));
        check({tag, ".bd"}, int'(cap_bd[sel]), int'(bd));
        check({tag, ".bdcnt"}, bd_cnt[sel] - bd_before, bd ? 1 : 0);
    endtask

    initial begin
        int a, b, lat;
        logic [8:0] d;
        bit pf;
        logic [1:0] sv;

        reset = 1'b1; ser0 = 1'b1; ser1 = 1'b1; ser2 = 1'b1;
        hold(4);
        check("rst.att", int'(att0), 0);
        check("rst.data", int'(data0), 0);
        check("rst.fe", int'(fe0), 0);
        check("rst.pe", int'(pe0), 0);
        check("rst.bd", int'(bd0), 0);
        check("rst.data2", int'(data2), 0);
        reset = 1'b0;
        hold(10);

        a = att_cnt[0]; b = bd_cnt[0];
        send(0, 9'h055, 1'b0, 2'b11, 1);
        expect_frame("f55", 0, a, b, 9'h055, 1'b0, 1'b0, 1'b0);
        lat = att_cyc[0] - start_cyc - (9 * P0 + P0 / 2 + 2);
        check("f55.latency_ok", int'(lat >= -2 && lat <= 2), 1);

        a = att_cnt[0]; b = bd_cnt[0];
        set_line(0, 1'b0); hold(100); set_line(0, 1'b1); hold(2 * P0);
        check("glitch.att", att_cnt[0] - a, 0);
        send(0, 9'h0A3, 1'b0, 2'b11, 1);
        expect_frame("fA3", 0, a, b, 9'h0A3, 1'b0, 1'b0, 1'b0);

        a = att_cnt[0]; b = bd_cnt[0];
        send(0, 9'h00F, 1'b0, 2'b00, 1);
        expect_frame("f0F_badstop", 0, a, b, 9'h00F, 1'b1, 1'b0, 1'b0);
        a = att_cnt[0];
        send(0, 9'h03C, 1'b0, 2'b11, 1);
        expect_frame("f3C", 0, a, b, 9'h03C, 1'b0, 1'b0, 1'b0);

        a = att_cnt[0]; b = bd_cnt[0];
        set_line(0, 1'b0); hold(20 * P0); set_line(0, 1'b1); hold(2 * P0);
        expect_frame("break", 0, a, b, 9'h000, 1'b1, 1'b0, 1'b1);
        a = att_cnt[0]; b = bd_cnt[0];
        send(0, 9'h07E, 1'b0, 2'b11, 1);
        expect_frame("f7E", 0, a, b, 9'h07E, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 2; k++) begin
            d = 9'($urandom_range(1, 255));
            a = att_cnt[0]; b = bd_cnt[0];
            send(0, d, 1'b0, 2'b11, 1);
            expect_frame("rnd0", 0, a, b, d, 1'b0, 1'b0, 1'b0);
        end

        a = att_cnt[1]; b = bd_cnt[1];
        send(1, 9'h041, 1'b0, 2'b11, 1);
        expect_frame("p41_ok", 1, a, b, 9'h041, 1'b0, 1'b0, 1'b0);
        a = att_cnt[1];
        send(1, 9'h041, 1'b1, 2'b11, 1);
        expect_frame("p41_bad", 1, a, b, 9'h041, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            d = 9'($urandom_range(1, 127));
            pf = bit'($urandom_range(0, 1));
            sv = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
            a = att_cnt[1]; b = bd_cnt[1];
            send(1, d, pf, sv, 1);
            expect_frame("rnd1", 1, a, b, d, ~sv[0], pf, 1'b0);
        end

        a = att_cnt[2]; b = bd_cnt[2];
        d = 9'h1AB;
        set_line(2, 1'b0); hold(P2);
        for (int i = 0; i < 4; i++) begin
            set_line(2, d[i]); hold(P2);
        end
        set_line(2, d[4]); hold(P2 / 2);
        reset = 1'b1; set_line(2, 1'b1); hold(3);
        check("abort.rst_att", int'(att2), 0);
        check("abort.rst_data", int'(data2), 0);
        reset = 1'b0;
        hold(20 * P2);
        check("abort.att", att_cnt[2] - a, 0);
        send(2, 9'h155, 1'b0, 2'b11, 1);
        expect_frame("f155", 2, a, b, 9'h155, 1'b0, 1'b0, 1'b0);
        a = att_cnt[2];
        send(2, 9'h0AA, 1'b0, 2'b01, 1);
        expect_frame("stop2_low", 2, a, b, 9'h0AA, 1'b1, 1'b0, 1'b0);
        a = att_cnt[2];
        send(2, 9'h133, 1'b0, 2'b10, 1);
        expect_frame("stop1_low", 2, a, b, 9'h133, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            d = 9'($urandom_range(1, 511));
            a = att_cnt[2];
            send(2, d, 1'b0, 2'b11, 1);
            expect_frame("rnd2", 2, a, b, d, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
